// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel mode
// encoding and default sizing constants.
package timer_pkg;

    typedef enum logic [0:0] {
        ONE_SHOT    = 1'b0,
        AUTO_RELOAD = 1'b1
    } timer_mode_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_PRESCALE_W = 4;

endpackage : timer_pkg

// File: rtl/timer_channel.sv
// One countdown channel: count and reload registers, load/decrement
// arbitration and the registered expiry pulse.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  timer_mode_e      mode,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] reload_r;
    logic             expire_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic [WIDTH-1:0] reload_nxt_s;
    logic             expire_nxt_s;

    // Next-state: load beats decrement; mode is only consulted at the 1->0 step.
    always_comb begin
        count_nxt_s  = count_r;
        reload_nxt_s = reload_r;
        expire_nxt_s = 1'b0;
        if (load) begin
            count_nxt_s  = load_value;
            reload_nxt_s = load_value;
        end else if (enable && tick && (count_r != CNT_ZERO)) begin
            if (count_r == CNT_ONE) begin
                expire_nxt_s = 1'b1;
                case (mode)
                    AUTO_RELOAD: count_nxt_s = reload_r;
                    ONE_SHOT:    count_nxt_s = CNT_ZERO;
                    default:     count_nxt_s = CNT_ZERO;
                endcase
            end else begin
                count_nxt_s = count_r - CNT_ONE;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= CNT_ZERO;
            reload_r <= CNT_ZERO;
            expire_r <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            reload_r <= reload_nxt_s;
            expire_r <= expire_nxt_s;
        end
    end

    assign count  = count_r;
    assign expire = expire_r;

endmodule : timer_channel

// File: rtl/multi_timer.sv
// Bank of independent countdown timers sharing one optional tick prescaler.
// Prescaler is compiled in only when MULTI_TIMER_PRESCALER_EN is defined.
module multi_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       auto_reload,
`ifdef MULTI_TIMER_PRESCALER_EN
    input  logic [PRESCALE_W-1:0]     prescale,
`endif
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       zero,
    output logic [CHANNELS-1:0]       expire,
    output logic                      busy
);

    logic tick_s;

`ifdef MULTI_TIMER_PRESCALER_EN
    localparam logic [PRESCALE_W-1:0] PS_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PS_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] ps_r;
    logic [PRESCALE_W-1:0] ps_nxt_s;

    // Tick fires when the shared divider has reached the programmed terminal value.
    always_comb begin
        ps_nxt_s = ps_r;
        if (ps_r >= prescale) begin
            tick_s   = 1'b1;
            ps_nxt_s = PS_ZERO;
        end else begin
            tick_s   = 1'b0;
            ps_nxt_s = ps_r + PS_ONE;
        end
    end

    // Shared prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_r <= PS_ZERO;
        end else begin
            ps_r <= ps_nxt_s;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            timer_channel #(
                .WIDTH (WIDTH)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .enable     (enable[gi]),
                .load       (load[gi]),
                .load_value (load_value[gi*WIDTH +: WIDTH]),
                .mode       (timer_mode_e'(auto_reload[gi])),
                .tick       (tick_s),
                .count      (count[gi*WIDTH +: WIDTH]),
                .expire     (expire[gi])
            );
            assign zero[gi] = (count[gi*WIDTH +: WIDTH] == {WIDTH{1'b0}});
        end
    endgenerate

    assign busy = |(~zero);

endmodule : multi_timer

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed vector table, reset and
// prescaler sequences, and randomized traffic against a behavioural model.
module tb_multi_timer;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   enable, load, auto_reload;
    logic [CH*W-1:0] load_value;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   zero, expire;
    logic            busy;
`ifdef MULTI_TIMER_PRESCALER_EN
    logic [3:0]      prescale = 4'd0;
`endif

    multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .auto_reload (auto_reload),
`ifdef MULTI_TIMER_PRESCALER_EN
        .prescale    (prescale),
`endif
        .count       (count),
        .zero        (zero),
        .expire      (expire),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_c[CH];
    int m_r[CH];
    bit m_e[CH];
    int m_ps;

    typedef struct {
        logic [CH-1:0]   ld;
        logic [CH-1:0]   en;
        logic [CH-1:0]   ar;
        logic [CH*W-1:0] lv;
        logic [CH*W-1:0] c;
        logic [CH-1:0]   ex;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_c[i] = 0; m_r[i] = 0; m_e[i] = 1'b0;
        end
        m_ps = 0;
    endtask

    task automatic model_edge();
        bit tk;
        int lv;
        tk = 1'b1;
`ifdef MULTI_TIMER_PRESCALER_EN
        tk = (m_ps >= int'(prescale));
        m_ps = tk ? 0 : m_ps + 1;
`endif
        for (int i = 0; i < CH; i++) begin
            lv = int'(load_value[i*W +: W]);
            m_e[i] = 1'b0;
            if (load[i]) begin
                m_c[i] = lv;
                m_r[i] = lv;
            end else if (enable[i] && tk && m_c[i] > 0) begin
                if (m_c[i] == 1) begin
                    m_e[i] = 1'b1;
                    m_c[i] = auto_reload[i] ? m_r[i] : 0;
                end else begin
                    m_c[i] = m_c[i] - 1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [CH*W-1:0] ec;
        logic [CH-1:0]   ee, ez;
        for (int i = 0; i < CH; i++) begin
            ec[i*W +: W] = m_c[i][W-1:0];
            ee[i] = m_e[i];
            ez[i] = (m_c[i] == 0);
        end
        chk({tag, "_count"}, count, ec);
        chk({tag, "_expire"}, 32'(expire), 32'(ee));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
        chk({tag, "_busy"}, 32'(busy), 32'(~&ez));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = '0; load = '0; auto_reload = '0; load_value = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [CH-1:0] zx;
        int waited;

        // Directed table: one-shot ch0, auto-reload ch1, load-over-expiry ch2, load 0 on ch3
        tbl[0]  = '{4'b0011, 4'b0011, 4'b0010, {8'd0, 8'd0, 8'd2, 8'd3}, {8'd0, 8'd0, 8'd2, 8'd3}, 4'b0000};
        tbl[1]  = '{4'b0000, 4'b0011, 4'b0010, 32'd0, {8'd0, 8'd0, 8'd1, 8'd2}, 4'b0000};
        tbl[2]  = '{4'b0000, 4'b0011, 4'b0010, 32'd0, {8'd0, 8'd0, 8'd2, 8'd1}, 4'b0010};
        tbl[3]  = '{4'b0000, 4'b0011, 4'b0010, 32'd0, {8'd0, 8'd0, 8'd1, 8'd0}, 4'b0001};
        tbl[4]  = '{4'b0000, 4'b0011, 4'b0010, 32'd0, {8'd0, 8'd0, 8'd2, 8'd0}, 4'b0010};
        tbl[5]  = '{4'b0000, 4'b0011, 4'b0010, 32'd0, {8'd0, 8'd0, 8'd1, 8'd0}, 4'b0000};
        tbl[6]  = '{4'b0000, 4'b0011, 4'b0010, 32'd0, {8'd0, 8'd0, 8'd2, 8'd0}, 4'b0010};
        tbl[7]  = '{4'b0100, 4'b0111, 4'b0010, {8'd0, 8'd1, 8'd0, 8'd0}, {8'd0, 8'd1, 8'd1, 8'd0}, 4'b0000};
        tbl[8]  = '{4'b0100, 4'b0111, 4'b0010, {8'd0, 8'd5, 8'd0, 8'd0}, {8'd0, 8'd5, 8'd2, 8'd0}, 4'b0010};
        tbl[9]  = '{4'b1000, 4'b1111, 4'b0010, 32'd0, {8'd0, 8'd4, 8'd1, 8'd0}, 4'b0000};
        tbl[10] = '{4'b0000, 4'b1111, 4'b0010, 32'd0, {8'd0, 8'd3, 8'd2, 8'd0}, 4'b0010};
        tbl[11] = '{4'b0000, 4'b1111, 4'b0010, 32'd0, {8'd0, 8'd2, 8'd1, 8'd0}, 4'b0000};

        do_reset();
        chk("reset_count", count, 32'h0);
        chk("reset_zero", 32'(zero), 32'hF);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_expire", 32'(expire), 32'h0);

        for (int i = 0; i < 12; i++) begin
            load = tbl[i].ld; enable = tbl[i].en; auto_reload = tbl[i].ar; load_value = tbl[i].lv;
            step();
            for (int c = 0; c < CH; c++) zx[c] = (tbl[i].c[c*W +: W] == 8'd0);
            chk($sformatf("tbl%0d_count", i), count, tbl[i].c);
            chk($sformatf("tbl%0d_expire", i), 32'(expire), 32'(tbl[i].ex));
            chk($sformatf("tbl%0d_zero", i), 32'(zero), 32'(zx));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(~&zx));
        end

        // Mode is sampled only at the 1->0 step: loaded auto-reload, switched to one-shot late
        do_reset();
        load = 4'b0001; load_value = 32'd2; auto_reload = 4'b0001; enable = 4'b0001;
        step();
        load = '0; step();
        auto_reload = 4'b0000; step();
        chk("mode_late_count", count, 32'h0);
        chk("mode_late_expire", 32'(expire), 32'h1);
        check_model("mode_late");

        // Reset mid-count on all channels aborts everything
        do_reset();
        load = 4'b1111; load_value = {8'd9, 8'd7, 8'd5, 8'd3}; enable = 4'b1111; auto_reload = 4'b1010;
        step();
        load = '0;
        repeat (2) begin step(); check_model("pre_rst"); end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count, 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_zero", 32'(zero), 32'hF);
        @(posedge clk); #2;
        model_reset();
        rst_n = 1'b1;
        repeat (5) begin step(); check_model("post_rst"); end

`ifdef MULTI_TIMER_PRESCALER_EN
        // Divided tick: ch0 loaded with 4, prescale 2
        do_reset();
        prescale = 4'd2;
        load = 4'b0001; load_value = 32'd4; enable = 4'b0001; auto_reload = '0;
        step();
        load = '0;
        waited = 0;
        while (!m_e[0] && waited < 40) begin
            step(); check_model("presc"); waited++;
        end
        chk("presc_bound", 32'(waited < 40), 32'h1);
        prescale = 4'd0;
`else
        waited = 0;
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CH; c++) begin
                load[c] = ($urandom_range(0, 7) == 0);
                load_value[c*W +: W] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
                enable[c] = ($urandom_range(0, 3) != 0);
                auto_reload[c] = 1'($urandom);
            end
`ifdef MULTI_TIMER_PRESCALER_EN
            if ($urandom_range(0, 49) == 0) prescale = 4'($urandom_range(0, 3));
`endif
            step();
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multi_timer
